// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiplier controller.
//   state_t     : controller states, visible on the debug port of the interface
//   ITERATIONS  : number of multiplier bits processed per multiply
//   CNT_W       : width of the iteration counter
//   LAST_ITER   : counter value of the final (sign) iteration
package multiplier_pkg;

  localparam int ITERATIONS = 8;
  localparam int CNT_W      = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/multiplier_control_if.sv
// Bundle between the multiplier controller and its environment.
//   run, clearA_loadB : button levels, asynchronous to clk
//   M                 : current B[0] from the datapath
//   shift_sig, add_sig, sub_sig, clear_A_load_B_sig : one-cycle datapath commands
//   busy, done        : status levels
//   state, cnt, run_sync, load_sync : debug view of the controller
// Handshake: there is no valid/ready pairing here. Commands are single-cycle
// strobes meaning "act on this rising clk edge"; the datapath must accept one
// every cycle, and at most one strobe is high at a time.
// Modports: master = the side driving the buttons and M (board / bench),
//           slave  = the controller.
interface multiplier_control_if;
  import multiplier_pkg::*;

  logic             run;
  logic             clearA_loadB;
  logic             M;
  logic             shift_sig;
  logic             add_sig;
  logic             sub_sig;
  logic             clear_A_load_B_sig;
  logic             busy;
  logic             done;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run_sync;
  logic             load_sync;

  modport master (
    output run, clearA_loadB, M,
    input  shift_sig, add_sig, sub_sig, clear_A_load_B_sig, busy, done,
    input  state, cnt, run_sync, load_sync
  );

  modport slave (
    input  run, clearA_loadB, M,
    output shift_sig, add_sig, sub_sig, clear_A_load_B_sig, busy, done,
    output state, cnt, run_sync, load_sync
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk, reset : clock, asynchronous active-high reset
//   async_in   : level from another clock domain
//   level      : synchronized level
//   rise       : one-cycle pulse on each 0->1 transition of level
// All flops clear on reset, so an input already high when reset releases
// produces one rise pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/multiplier_control.sv
// Control unit for an 8-bit signed shift-add multiplier.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : multiplier_control_if.slave (buttons, M in; strobes, status,
//                debug state out)
// Each multiply runs 8 EVAL/SHIFT pairs (16 cycles). EVAL adds the
// multiplicand when M=1, except on the last iteration where it subtracts
// (the sign bit of a two's-complement multiplier has negative weight).
// Strobes are decoded combinationally from state, cnt and M.
module multiplier_control
  import multiplier_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  multiplier_control_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic run_level, run_rise;
  logic load_level, load_rise;

  logic shift_c, add_c, sub_c, clr_c, busy_c, done_c;

  sync_edge u_run_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.run),
    .level    (run_level),
    .rise     (run_rise)
  );

  sync_edge u_load_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.clearA_loadB),
    .level    (load_level),
    .rise     (load_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Edges are only looked at in IDLE, so anything arriving in other states is
  // dropped rather than queued. Load has priority over run in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_c   = 1'b0;
    add_c     = 1'b0;
    sub_c     = 1'b0;
    clr_c     = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (load_rise) begin
          state_nxt = LOAD;
        end else if (run_rise) begin
          cnt_nxt   = '0;
          state_nxt = EVAL;
        end
      end
      LOAD: begin
        clr_c     = 1'b1;
        state_nxt = IDLE;
      end
      EVAL: begin
        busy_c = 1'b1;
        if (bus.M) begin
          if (cnt == LAST_ITER) sub_c = 1'b1;
          else                  add_c = 1'b1;
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_c  = 1'b1;
        shift_c = 1'b1;
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = EVAL;
        end
      end
      DONE: begin
        done_c = 1'b1;
        // Waiting for run to drop forces a fresh press for the next multiply.
        if (!run_level) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.shift_sig          = shift_c;
  assign bus.add_sig            = add_c;
  assign bus.sub_sig            = sub_c;
  assign bus.clear_A_load_B_sig = clr_c;
  assign bus.busy               = busy_c;
  assign bus.done               = done_c;
  assign bus.state              = state;
  assign bus.cnt                = cnt;
  assign bus.run_sync           = run_level;
  assign bus.load_sync          = load_level;

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control. A small B-register model feeds M:
// it loads on clear_A_load_B_sig and shifts right on shift_sig. All time
// advances through tick(), which samples the outputs at the falling edge.
module tb_multiplier_control;
  import multiplier_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multiplier_control_if ifc ();

  multiplier_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // ---------------- datapath model ----------------
  logic [7:0] b_in  = 8'h00;
  logic [7:0] b_reg = 8'h00;

  always @(posedge clk) begin
    if (ifc.clear_A_load_B_sig) b_reg <= b_in;
    else if (ifc.shift_sig)     b_reg <= {1'b0, b_reg[7:1]};
  end
  assign ifc.M = b_reg[0];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int add_cnt, sub_cnt, shift_cnt, clr_cnt, busy_cyc, viol;
  logic [31:0] add_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    add_cnt = 0; sub_cnt = 0; shift_cnt = 0; clr_cnt = 0;
    busy_cyc = 0; viol = 0; add_mask = '0;
  endtask

  task automatic tick();
    int n;
    @(negedge clk);
    n = int'(ifc.add_sig) + int'(ifc.sub_sig) + int'(ifc.shift_sig) + int'(ifc.clear_A_load_B_sig);
    if (n > 1) viol++;
    if ((ifc.add_sig || ifc.sub_sig || ifc.shift_sig) && !ifc.busy) viol++;
    if (ifc.add_sig) begin
      add_cnt++;
      add_mask |= (32'd1 << shift_cnt);
    end
    if (ifc.sub_sig) sub_cnt++;
    if (ifc.shift_sig) shift_cnt++;
    if (ifc.clear_A_load_B_sig) clr_cnt++;
    if (ifc.busy) busy_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_b(input logic [7:0] b);
    b_in = b;
    ifc.clearA_loadB = 1'b1;
    repeat (4) tick();
    ifc.clearA_loadB = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_multiply(input string name, input logic [7:0] b,
                             input int exp_add, input logic [31:0] exp_mask,
                             input int exp_sub);
    int lat;
    int guard;
    load_b(b);
    check({name, "_load_pulses"}, clr_cnt, 1);
    clear_counts();
    ifc.run = 1'b1;
    lat = 0;
    while (!ifc.busy && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_start_latency"}, lat, 3);
    guard = 0;
    while (!ifc.done && guard < 40) begin
      tick();
      guard++;
    end
    check({name, "_done_reached"}, ifc.done, 1'b1);
    check({name, "_busy_cycles"}, busy_cyc, 16);
    check({name, "_add_count"}, add_cnt, exp_add);
    check({name, "_add_iters"}, add_mask, exp_mask);
    check({name, "_sub_count"}, sub_cnt, exp_sub);
    check({name, "_shift_count"}, shift_cnt, 8);
    check({name, "_busy_in_done"}, ifc.busy, 1'b0);
    check({name, "_strobe_rules"}, viol, 0);
    ifc.run = 1'b0;
    repeat (4) tick();
    check({name, "_done_cleared"}, ifc.done, 1'b0);
    check({name, "_back_idle"}, 32'(ifc.state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    ifc.run = 1'b0;
    ifc.clearA_loadB = 1'b0;
    clear_counts();

    repeat (3) tick();
    check("reset_state", 32'(ifc.state), 32'(IDLE));
    check("reset_cnt", 32'(ifc.cnt), 0);
    check("reset_outputs",
          {ifc.shift_sig, ifc.add_sig, ifc.sub_sig, ifc.clear_A_load_B_sig, ifc.busy, ifc.done}, 6'b0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_after_release", 32'(ifc.state), 32'(IDLE));

    // B=05: adds at iterations 0 and 2; B=FF: 7 adds then sub; B=80: sub only
    do_multiply("b05", 8'h05, 2, 32'h05, 0);
    do_multiply("bff", 8'hFF, 7, 32'h7F, 1);
    do_multiply("b80", 8'h80, 0, 32'h00, 1);

    // Load and run edges in the same IDLE cycle: load wins, run discarded
    clear_counts();
    b_in = 8'h05;
    ifc.clearA_loadB = 1'b1;
    ifc.run = 1'b1;
    repeat (8) tick();
    check("both_load_pulses", clr_cnt, 1);
    check("both_no_busy", busy_cyc, 0);
    check("both_state", 32'(ifc.state), 32'(IDLE));
    ifc.clearA_loadB = 1'b0;
    ifc.run = 1'b0;
    repeat (4) tick();
    check("both_still_no_busy", busy_cyc, 0);

    // Reset in the 5th busy cycle aborts the multiply
    load_b(8'hFF);
    clear_counts();
    ifc.run = 1'b1;
    guard = 0;
    while (busy_cyc < 5 && guard < 20) begin
      tick();
      guard++;
    end
    check("abort_reached_5th_busy", busy_cyc, 5);
    reset = 1'b1;
    #1;
    check("abort_outputs",
          {ifc.shift_sig, ifc.add_sig, ifc.sub_sig, ifc.clear_A_load_B_sig, ifc.busy, ifc.done}, 6'b0);
    check("abort_state", 32'(ifc.state), 32'(IDLE));
    check("abort_cnt", 32'(ifc.cnt), 0);
    ifc.run = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    check("abort_stays_idle", 32'(ifc.state), 32'(IDLE));
    check("abort_no_more_busy", busy_cyc, 5);
    check("abort_shift_count", shift_cnt, 2);
    check("abort_strobe_rules", viol, 0);

    // Run held for 40 cycles: one multiply, done held until run falls
    load_b(8'h05);
    clear_counts();
    ifc.run = 1'b1;
    repeat (40) tick();
    check("hold_busy_cycles", busy_cyc, 16);
    check("hold_shift_count", shift_cnt, 8);
    check("hold_add_count", add_cnt, 2);
    check("hold_done_held", ifc.done, 1'b1);
    ifc.run = 1'b0;
    repeat (4) tick();
    check("hold_done_cleared", ifc.done, 1'b0);
    check("hold_idle", 32'(ifc.state), 32'(IDLE));
    check("hold_no_second_run", busy_cyc, 16);

    // Run already high while reset releases gives exactly one start,
    // operating on the existing B contents (no reload)
    load_b(8'h05);
    reset = 1'b1;
    ifc.run = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clear_counts();
    guard = 0;
    while (!ifc.done && guard < 40) begin
      tick();
      guard++;
    end
    check("rst_run_high_done", ifc.done, 1'b1);
    check("rst_run_high_busy", busy_cyc, 16);
    check("rst_run_high_adds", add_mask, 32'h05);
    ifc.run = 1'b0;
    repeat (4) tick();
    check("rst_run_high_idle", 32'(ifc.state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port run, input, 1 bit: Run button level, asynchronous to clk.
REQ-004 SHALL have port clearA_loadB, input, 1 bit: ClearA_LoadB button level, asynchronous to clk.
REQ-005 SHALL have port M, input, 1 bit: current B[0] from the datapath.
REQ-006 SHALL have outputs shift_sig, add_sig, sub_sig, clear_A_load_B_sig, 1 bit each: command strobes to the datapath.
REQ-007 SHALL have output busy, 1 bit: high while a multiply is in progress.
REQ-008 SHALL have output done, 1 bit: high while in DONE.

Function
REQ-009 SHALL pass run and clearA_loadB through a two-flop synchronizer each, then a rising-edge detector; each edge is a one-cycle internal pulse.
REQ-010 SHALL implement states IDLE, LOAD, EVAL, SHIFT, DONE, plus a 3-bit iteration counter cnt.
REQ-011 IDLE: on a clearA_loadB edge go to LOAD; else on a run edge clear cnt to 0 and go to EVAL; else stay in IDLE.
REQ-012 LOAD: assert clear_A_load_B_sig for exactly one cycle, then go to IDLE.
REQ-013 EVAL with M=1: assert add_sig if cnt<7, or sub_sig if cnt==7. EVAL with M=0: assert no strobe. Always go to SHIFT next cycle.
REQ-014 SHIFT: assert shift_sig for one cycle. If cnt==7 go to DONE, else increment cnt and go to EVAL.
REQ-015 DONE: stay while synchronized run is high; go to IDLE once it is low.
REQ-016 Each multiply SHALL take exactly 16 cycles in EVAL/SHIFT: 8 iterations of 2 cycles each, independent of M.
REQ-017 At most one of the four strobes SHALL be high in any cycle; all are 0 in IDLE and DONE.
REQ-018 Strobes SHALL be decoded combinationally from state, cnt and M; there is no registered output delay.
REQ-019 busy SHALL be 1 in EVAL and SHIFT only. done SHALL be 1 in DONE only.
REQ-020 Latency: run first sampled high at clock edge k gives EVAL after edge k+2, and the first strobe in cycle k+3.
REQ-021 A clearA_loadB edge and a run edge in the same IDLE cycle: LOAD wins and the run edge is discarded.
REQ-022 Edges of run or clearA_loadB during LOAD, EVAL, SHIFT or DONE SHALL be ignored (not queued).
REQ-023 Holding run high after DONE SHALL NOT start a new multiply; run must go low, then high again.
REQ-024 A repeated run with no intervening load SHALL start a new multiply on the existing datapath contents; this block issues no A/X clear.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, cnt=0, all synchronizer and edge flops to 0, and all outputs to 0.
REQ-026 Reset during EVAL or SHIFT SHALL abort the multiply with no further strobes.
REQ-027 After reset deasserts, a run level already high SHALL produce one edge (the synchronizer reads 0 to 1).

Structure
REQ-028 A shared package multiplier_pkg SHALL hold the state enum typedef and the constant ITERATIONS=8.
REQ-029 Synchronizer plus edge detect SHALL be one sub-module, sync_edge, instantiated twice.
REQ-030 The state register and cnt SHALL sit in one always_ff with async reset; next-state and strobe decode in one always_comb.

Verification
REQ-031 Bench SHALL cover: M sequence 1,0,1,0,0,0,0,0 (B=8'h05) -> add_sig at iterations 0 and 2, 0 sub, 8 shift_sig, busy exactly 16 cycles.
REQ-032 Bench SHALL cover: M all 1 (B=8'hFF) -> 7 add_sig, then 1 sub_sig at cnt=7, 8 shift_sig, then done=1.
REQ-033 Bench SHALL cover: M=1 only at iteration 7 (B=8'h80) -> 0 add_sig, 1 sub_sig, 8 shift_sig.
REQ-034 Bench SHALL cover: clearA_loadB and run rising in the same cycle from IDLE -> one clear_A_load_B_sig pulse, no busy, state back to IDLE.
REQ-035 Bench SHALL cover: reset asserted at the 5th busy cycle -> all outputs 0 in the same cycle; after release with run low, state stays IDLE.
REQ-036 Bench SHALL cover: run held high 40 cycles -> exactly one multiply, done held until run falls, then IDLE.
